// File: rtl/neuron_mac16.sv
// neuron_mac16 -- sequential single-neuron dot-product engine, IEEE 754 half precision.
//   Streams N_INPUTS x/w pairs through one multi16 and one sum16 and accumulates
//   onto a bias. The output is y = act(bias + sum x[i]*w[i]).
//   Optional build macro: NEURON_RELU_EN. When it is defined, act() is ReLU.
//   When it is undefined, act() passes the value through unchanged.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, bias          begin an evaluation in IDLE, latching bias
//   in_valid/in_ready, x, w   input pair stream
//   out_valid/out_ready, y    registered result handshake
//   busy                 high whenever not IDLE
// Also contains the multi16 / sum16 half-precision units. These units truncate,
// always infer a hidden 1, and let the exponent wrap on overflow.

// Half-precision multiplier. Returns +0 when either operand has a zero exponent
// or when the product underflows.
module multi16 (
   input  logic        en,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] p
);
   logic [21:0] prod;
   logic [6:0]  e_sum;
   logic        norm;
   logic        unused_bits;

   assign unused_bits = ^prod[9:0];

   always_comb begin
      prod  = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      norm  = prod[21];
      e_sum = 7'(a[14:10]) + 7'(b[14:10]) + 7'(norm);
      p     = '0;
      if (en && (a[14:10] != 5'd0) && (b[14:10] != 5'd0) && (e_sum > 7'd15)) begin
         p[15]    = a[15] ^ b[15];
         p[14:10] = 5'(e_sum - 7'd15);
         p[9:0]   = norm ? prod[20:11] : prod[19:10];
      end
   end
endmodule

// Half-precision adder. It carries 3 guard bits and truncates the result.
// Exact cancellation gives 16'h0000.
module sum16 (
   input  logic        en,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] s
);
   logic [15:0] big, sml;
   logic [4:0]  d;
   logic [13:0] mb, ms, diff, sh;
   logic [14:0] tot;
   logic [3:0]  lz;
   logic        found;
   logic        unused_bits;

   assign unused_bits = ^{tot[2:0], sh[13], sh[2:0]};

   always_comb begin
      big   = (a[14:0] >= b[14:0]) ? a : b;
      sml   = (a[14:0] >= b[14:0]) ? b : a;
      d     = big[14:10] - sml[14:10];
      mb    = {1'b1, big[9:0], 3'b000};
      ms    = (d > 5'd13) ? 14'd0 : ({1'b1, sml[9:0], 3'b000} >> d);
      tot   = 15'(mb) + 15'(ms);
      diff  = mb - ms;
      // leading-zero count for renormalising after subtraction
      lz    = '0;
      found = 1'b0;
      for (int i = 13; i >= 0; i--) begin
         if (!found && diff[i]) begin
            lz    = 4'(13 - i);
            found = 1'b1;
         end
      end
      sh = diff << lz;
      s  = '0;
      if (en) begin
         if (big[15] == sml[15]) begin
            s[15] = big[15];
            if (tot[14]) begin
               s[14:10] = big[14:10] + 5'd1;
               s[9:0]   = tot[13:4];
            end else begin
               s[14:10] = big[14:10];
               s[9:0]   = tot[12:3];
            end
         end else if ((diff != 14'd0) && (big[14:10] > {1'b0, lz})) begin
            s[15]    = big[15];
            s[14:10] = big[14:10] - {1'b0, lz};
            s[9:0]   = sh[12:3];
         end
      end
   end
endmodule

module neuron_mac16 #(
   parameter int tam      = 16,   // only 16 supported
   parameter int N_INPUTS = 4,    // 1..255
   parameter int CNT_W    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [tam-1:0] bias,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [tam-1:0] x,
   input  logic [tam-1:0] w,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [tam-1:0] y,
   output logic           busy
);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t           state_q, state_d;
   logic [tam-1:0]   acc, acc_next, p, s;
   logic [CNT_W-1:0] cnt;
   logic             accept, last;

   function automatic logic [tam-1:0] act(input logic [tam-1:0] v);
`ifdef NEURON_RELU_EN
      return v[tam-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   multi16 u_mul (.en(1'b1), .a(x),   .b(w), .p(p));
   sum16   u_add (.en(1'b1), .a(acc), .b(p), .s(s));

   assign accept = (state_q == ACC) && in_valid;
   assign last   = (cnt == CNT_W'(N_INPUTS - 1));

   // The adder always infers a hidden 1, so an exact zero on either side is
   // bypassed instead of being added.
   always_comb begin
      if (p == '0)               acc_next = acc;
      else if (acc[14:0] == '0)  acc_next = p;
      else                       acc_next = s;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = (state_q != IDLE);
      case (state_q)
         IDLE: if (start) state_d = ACC;
         ACC: begin
            in_ready = 1'b1;
            if (accept && last) state_d = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         y         <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               acc <= bias;
               cnt <= '0;
            end
            ACC: if (accept) begin
               acc <= acc_next;
               if (last) begin
                  // result is registered as DONE is entered
                  y         <= act(acc_next);
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_mac16.sv
module tb_neuron_mac16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 0, in_valid = 0, out_ready = 0;
  logic [15:0] bias = 0, x = 0, w = 0;
  logic        in_ready, out_valid, busy;
  logic [15:0] y;

  logic        start1 = 0, in_valid1 = 0, out_ready1 = 0;
  logic [15:0] bias1 = 0, x1 = 0, w1 = 0;
  logic        in_ready1, out_valid1, busy1;
  logic [15:0] y1;

  int checks = 0;
  int errors = 0;

  neuron_mac16 #(.tam(16), .N_INPUTS(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .w(w), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy));

  neuron_mac16 #(.tam(16), .N_INPUTS(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bias(bias1), .in_valid(in_valid1),
    .in_ready(in_ready1), .x(x1), .w(w1), .out_valid(out_valid1), .out_ready(out_ready1),
    .y(y1), .busy(busy1));

  // value pool: every product and sum of these is exactly representable
  logic [15:0] vals [12] = '{16'h0000, 16'h8000, 16'h3800, 16'hB800, 16'h3C00, 16'hBC00,
                             16'h3E00, 16'hBE00, 16'h4000, 16'hC000, 16'h4200, 16'hC200};

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    real a;
    int  e, m;
    logic sg;
    if (v == 0.0) return 16'h0000;
    sg = (v < 0.0);
    a  = sg ? -v : v;
    e  = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    return {sg, e[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] act_m(input logic [15:0] v);
`ifdef NEURON_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  // zero products leave the bias untouched; otherwise the result is the exact sum
  function automatic logic [15:0] model(input logic [15:0] b, input logic [15:0] xs [4],
                                        input logic [15:0] ws [4], input int n);
    real sum, pr;
    bit  any;
    sum = h2r(b);
    any = 0;
    for (int i = 0; i < n; i++) begin
      pr = h2r(xs[i]) * h2r(ws[i]);
      if (pr != 0.0) any = 1;
      sum = sum + pr;
    end
    return act_m(any ? r2h(sum) : b);
  endfunction

  // ---------------- stimulus driver for the N_INPUTS=2 instance ----------------
  task automatic run_eval(input logic [15:0] b, input logic [15:0] xs [4],
                          input logic [15:0] ws [4], input int n, input int gap,
                          input bit ack, output logic [15:0] yv, output int lat,
                          output bit to);
    int k;
    start = 1; bias = b;
    @(posedge clk); #1;
    start = 0; lat = 1;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; lat++; end
      in_valid = 1; x = xs[i]; w = ws[i];
      @(posedge clk); #1;
      lat++;
      in_valid = 0;
    end
    k = 0;
    while (!out_valid && k < 20) begin @(posedge clk); #1; lat++; k++; end
    to = !out_valid;
    yv = y;
    if (ack) begin
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({y, out_valid, in_ready, busy} !== 19'd0) begin
      errors++; $display("FAIL reset0 got y=%h ov=%b ir=%b busy=%b want all 0", y, out_valid, in_ready, busy);
    end
    checks++;
    if ({y1, out_valid1, in_ready1, busy1} !== 19'd0) begin
      errors++; $display("FAIL reset1 got y=%h ov=%b ir=%b busy=%b want all 0", y1, out_valid1, in_ready1, busy1);
    end
  endtask

  task automatic test_basic();
    logic [15:0] xs [4], ws [4], yv;
    int lat; bit to;
    xs = '{16'h3C00, 16'h3800, 0, 0}; ws = '{16'h4000, 16'h4000, 0, 0};
    run_eval(16'h0000, xs, ws, 2, 0, 1, yv, lat, to);
    checks++;
    if (to || yv !== 16'h4200) begin errors++; $display("FAIL basic_y got %h want 4200 (timeout=%b)", yv, to); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d edges want 3", lat); end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle got ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] xs [4], ws [4], yv;
    int lat; bit to;
    xs = '{16'h4000, 16'hBC00, 0, 0}; ws = '{16'h4000, 16'h3C00, 0, 0};
    for (int g = 0; g <= 3; g += 3) begin
      run_eval(16'h3C00, xs, ws, 2, g, 1, yv, lat, to);
      checks++;
      if (to || yv !== 16'h4400) begin errors++; $display("FAIL gap%0d_y got %h want 4400", g, yv); end
      checks++;
      if (lat !== 3 + 2 * g) begin errors++; $display("FAIL gap%0d_latency got %0d want %0d", g, lat, 3 + 2 * g); end
    end
  endtask

  task automatic test_zero_products();
    logic [15:0] xs [4], ws [4], yv, exp_y;
    int lat; bit to;
`ifdef NEURON_RELU_EN
    exp_y = 16'h0000;
`else
    exp_y = 16'hBC00;
`endif
    xs = '{16'h0000, 16'h4000, 0, 0}; ws = '{16'h4000, 16'h0000, 0, 0};
    run_eval(16'hBC00, xs, ws, 2, 0, 1, yv, lat, to);
    checks++;
    if (to || yv !== exp_y) begin errors++; $display("FAIL zero_prod got %h want %h", yv, exp_y); end
  endtask

  task automatic test_backpressure();
    logic [15:0] xs [4], ws [4], yv;
    int lat; bit to;
    xs = '{16'h3C00, 16'h3E00, 0, 0}; ws = '{16'h4200, 16'h3C00, 0, 0};
    run_eval(16'h3800, xs, ws, 2, 0, 0, yv, lat, to);
    checks++;
    if (to || yv !== model(16'h3800, xs, ws, 2)) begin
      errors++; $display("FAIL stall_y got %h want %h", yv, model(16'h3800, xs, ws, 2));
    end
    for (int c = 0; c < 5; c++) begin
      start = c[0]; bias = 16'h4200;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || y !== yv || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got ov=%b y=%h ir=%b busy=%b want 1 %h 0 1", c, out_valid, y, in_ready, busy, yv);
      end
    end
    // handshake and start on the same edge: only the handshake counts
    out_ready = 1; start = 1;
    @(posedge clk); #1;
    out_ready = 0; start = 0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_release got ov=%b busy=%b want 0 0", out_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL start_in_done got busy=%b ir=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] xs [4], ws [4], yv;
    int lat; bit to;
    start = 1; bias = 16'h4000;
    @(posedge clk); #1;
    start = 0; in_valid = 1; x = 16'h4000; w = 16'h4000;
    @(posedge clk); #1;
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({y, out_valid, in_ready, busy} !== 19'd0) begin
      errors++; $display("FAIL async_reset got y=%h ov=%b ir=%b busy=%b want all 0", y, out_valid, in_ready, busy);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    xs = '{16'h3C00, 16'h3C00, 0, 0}; ws = '{16'h3C00, 16'h3C00, 0, 0};
    run_eval(16'h0000, xs, ws, 2, 0, 1, yv, lat, to);
    checks++;
    if (to || yv !== 16'h4000) begin errors++; $display("FAIL after_reset_y got %h want 4000", yv); end
  endtask

  task automatic test_single_input();
    logic [15:0] xs [4], ws [4], exp_y, yv;
    xs = '{16'h3800, 0, 0, 0}; ws = '{16'h4000, 0, 0, 0};
    exp_y = model(16'h3800, xs, ws, 1);
    start1 = 1; bias1 = 16'h3800;
    @(posedge clk); #1;
    bias1 = 16'h4400;                 // start while busy: must be ignored
    @(posedge clk); #1;
    start1 = 0;
    checks++;
    if (busy1 !== 1'b1 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      errors++; $display("FAIL n1_acc got busy=%b ir=%b ov=%b want 1 1 0", busy1, in_ready1, out_valid1);
    end
    in_valid1 = 1; x1 = 16'h3800; w1 = 16'h4000;
    @(posedge clk); #1;
    in_valid1 = 0;
    checks++;
    if (out_valid1 !== 1'b1 || y1 !== exp_y) begin
      errors++; $display("FAIL n1_y got ov=%b y=%h want 1 %h", out_valid1, y1, exp_y);
    end
    yv = y1;
    start1 = 1;
    @(posedge clk); #1;
    start1 = 0;
    checks++;
    if (out_valid1 !== 1'b1 || y1 !== yv || in_ready1 !== 1'b0) begin
      errors++; $display("FAIL n1_start_in_done got ov=%b y=%h ir=%b want 1 %h 0", out_valid1, y1, in_ready1, yv);
    end
    out_ready1 = 1;
    @(posedge clk); #1;
    out_ready1 = 0;
    checks++;
    if (busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
      errors++; $display("FAIL n1_idle got busy=%b ov=%b want 0 0", busy1, out_valid1);
    end
  endtask

  task automatic test_random();
    logic [15:0] xs [4], ws [4], b, yv, exp_y;
    int lat, gap, hold; bit to;
    for (int it = 0; it < 40; it++) begin
      b = vals[$urandom_range(11)];
      for (int i = 0; i < 4; i++) begin
        xs[i] = vals[$urandom_range(11)];
        ws[i] = vals[$urandom_range(11)];
      end
      gap  = $urandom_range(2);
      hold = $urandom_range(3);
      exp_y = model(b, xs, ws, 2);
      run_eval(b, xs, ws, 2, gap, 0, yv, lat, to);
      checks++;
      if (to || yv !== exp_y) begin
        errors++; $display("FAIL rand%0d b=%h x=%h,%h w=%h,%h got %h want %h (timeout=%b)",
                           it, b, xs[0], xs[1], ws[0], ws[1], yv, exp_y, to);
      end
      repeat (hold) begin @(posedge clk); #1; end
      checks++;
      if (out_valid !== 1'b1 || y !== exp_y) begin
        errors++; $display("FAIL rand%0d_hold got ov=%b y=%h want 1 %h", it, out_valid, y, exp_y);
      end
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
    end
  endtask

  initial begin
    #12;
    test_reset();
    #1 rst_n = 1;
    @(posedge clk); #1;
    test_basic();
    test_gaps();
    test_zero_products();
    test_backpressure();
    test_async_reset();
    test_single_input();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
